// File: rtl/fft_frame_uart_tx.sv
// fft_frame_uart_tx
//
// Captures one frame of DEPTH FFT samples into on-chip storage and then
// streams it to the MCU as 8N1 UART bytes. Each sample goes out as
// ceil(DATA_W/8) bytes, LSB byte first, with the top byte zero-padded. The
// MCU paces the stream with rx_ready, which is only looked at between bytes.
//
// Optional feature: define FRAME_HEADER_EN to prefix every frame with the
// two bytes 0xA5, 0x5A. These header bytes use the same rx_ready pacing as
// the sample bytes.
module fft_frame_uart_tx #(
  parameter int DATA_W  = 14,
  parameter int DEPTH   = 1024,
  parameter int CLK_DIV = 868
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_re,
  input  logic              rx_ready,
  output logic              tx_ready,
  output logic              data_out,
  output logic              frame_drop
);

  localparam int B  = (DATA_W + 7) / 8;          // bytes per sample
  localparam int AW = $clog2(DEPTH);             // frame address width
  localparam int SW = (B > 1) ? $clog2(B) : 1;   // byte-select width
  localparam int DW = $clog2(CLK_DIV);           // bit-timer width

  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [SW-1:0] SEL_LAST = SW'(B - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    SEND
  } state_t;

  state_t            state, state_next;

  // Capture side
  logic              vld_d;
  logic              vld_rise;
  logic              wr_en;
  logic [AW-1:0]     wr_ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  // Read / byte sequencing side
  logic [AW-1:0]     rd_ptr;
  logic [SW-1:0]     byte_sel;
  logic [DATA_W-1:0] rd_data;
  logic [B*8-1:0]    rd_pad;
  logic [7:0]        sample_byte;
  logic [7:0]        cur_byte;
  logic              in_hdr;
  logic              cur_is_last;
  logic              last_loaded;

  // Serialiser
  logic              busy;
  logic [DW-1:0]     div_cnt;
  logic [3:0]        bit_idx;
  logic [8:0]        shreg;
  logic              bit_end;
  logic              byte_end;
  logic              load_byte;

  // A capture may only start on a fresh rising edge of data_valid.
  assign vld_rise = data_valid & ~vld_d;

  // The bit timer expires on the last cycle of a bit. The byte ends when the
  // stop bit (index 9) expires.
  assign bit_end  = busy && (div_cnt == DIV_LAST);
  assign byte_end = bit_end && (bit_idx == 4'd9);

  // State register.
  // NOTE: all clocked state is updated with non-blocking assignments so that
  // every always_ff reads the pre-edge values, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and per-cycle strobes for capture and byte launch.
  // NOTE: every output of this block gets a default first; without one, a path
  // that leaves a signal unassigned would infer a latch.
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    load_byte  = 1'b0;
    unique case (state)
      IDLE: begin
        if (vld_rise) begin
          wr_en      = 1'b1;
          state_next = FILL;
        end
      end
      FILL: begin
        if (data_valid) begin
          wr_en = 1'b1;
          if (wr_ptr == PTR_LAST) state_next = SEND;
        end
      end
      SEND: begin
        if (byte_end && last_loaded) begin
          state_next = IDLE;
        end else if (rx_ready && (!busy || byte_end) && !last_loaded) begin
          load_byte = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Edge detector, drop pulse and frame-ready flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_d      <= 1'b0;
      frame_drop <= 1'b0;
      tx_ready   <= 1'b0;
    end else begin
      vld_d      <= data_valid;
      frame_drop <= (state == SEND) && vld_rise;
      tx_ready   <= (state_next == SEND);
    end
  end

  // Write pointer: it starts at 0 in IDLE and wraps back to 0 after DEPTH-1.
  always_ff @(posedge clk) begin
    if (rst)        wr_ptr <= '0;
    else if (wr_en) wr_ptr <= wr_ptr + AW'(1);
  end

  // Frame storage with a registered read port. The read runs one cycle ahead.
  // NOTE: the storage array and its read register are deliberately not reset.
  // Stale contents are never sent, because a frame must be fully rewritten
  // before the block can enter SEND.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= data_re;
    rd_data <= mem[rd_ptr];
  end

  // Zero-pad the sample to a whole number of bytes and pick the current byte.
  always_comb begin
    rd_pad      = (B*8)'(rd_data);
    sample_byte = 8'h00;
    for (int k = 0; k < B; k++) begin
      if (byte_sel == SW'(k)) sample_byte = rd_pad[k*8 +: 8];
    end
  end

`ifdef FRAME_HEADER_EN
  logic [1:0] hdr_idx;

  // Header progress: 0 means 0xA5 is next, 1 means 0x5A is next, 2 means the
  // header is done.
  always_ff @(posedge clk) begin
    if (rst || state != SEND)     hdr_idx <= 2'd0;
    else if (load_byte && in_hdr) hdr_idx <= hdr_idx + 2'd1;
  end

  // Send the header bytes first, then the sample bytes.
  always_comb begin
    in_hdr   = (hdr_idx != 2'd2);
    cur_byte = sample_byte;
    if (hdr_idx == 2'd0)      cur_byte = 8'hA5;
    else if (hdr_idx == 2'd1) cur_byte = 8'h5A;
  end
`else
  // With no header, the stream starts directly with sample 0's LSB byte.
  always_comb begin
    in_hdr   = 1'b0;
    cur_byte = sample_byte;
  end
`endif

  assign cur_is_last = !in_hdr && (rd_ptr == PTR_LAST) && (byte_sel == SEL_LAST);

  // Byte sequencing: step the byte select and then the sample address as
  // each byte launches. Remember when the final byte has gone out.
  always_ff @(posedge clk) begin
    if (rst || state != SEND) begin
      rd_ptr      <= '0;
      byte_sel    <= '0;
      last_loaded <= 1'b0;
    end else if (load_byte) begin
      if (cur_is_last) last_loaded <= 1'b1;
      if (!in_hdr) begin
        if (byte_sel == SEL_LAST) begin
          byte_sel <= '0;
          rd_ptr   <= rd_ptr + AW'(1);
        end else begin
          byte_sel <= byte_sel + SW'(1);
        end
      end
    end
  end

  // 8N1 serialiser. The start bit is driven at launch, then data LSB first,
  // then the stop bit. A launch on the edge that ends a stop bit gives
  // back-to-back bytes with no idle cycle between them.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      div_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= '1;
      data_out <= 1'b1;
    end else if (load_byte) begin
      busy     <= 1'b1;
      div_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= {1'b1, cur_byte};
      data_out <= 1'b0;
    end else if (byte_end) begin
      busy     <= 1'b0;
      div_cnt  <= '0;
      bit_idx  <= '0;
      data_out <= 1'b1;
    end else if (bit_end) begin
      div_cnt  <= '0;
      bit_idx  <= bit_idx + 4'd1;
      data_out <= shreg[0];
      shreg    <= {1'b1, shreg[8:1]};
    end else if (busy) begin
      div_cnt  <= div_cnt + DW'(1);
    end
  end

endmodule

// File: doc/fft_frame_uart_tx.md
# fft_frame_uart_tx

Parametrised frame buffer and UART serialiser for FFT output samples. It captures one complete frame of `DEPTH` valid samples into internal single-clock storage, then streams the frame out as 8N1 UART bytes to the MCU. Transmission is paced by the MCU's `rx_ready` flow control at byte granularity. It sits between the FFT core's output stream and the MCU UART pin, and replaces the fixed 14-bit, dual-clock FIFO control path with one clock domain and a configurable width, depth and baud rate.

## Interface
Parameters:
- `DATA_W`, 14: sample width, 1..32.
- `DEPTH`, 1024: samples per frame; power of two, at least 2.
- `CLK_DIV`, 868: clock cycles per UART bit (100 MHz / 115200); at least 2.

Ports:
- `clk`, in, 1: system clock; all logic on rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `data_valid`, in, 1: FFT sample valid.
- `data_re`, in, `DATA_W`: FFT sample.
- `rx_ready`, in, 1: MCU ready to receive; level-sensitive.
- `tx_ready`, out, 1: a full frame is buffered and transmission is pending or in progress.
- `data_out`, out, 1: UART TX line; idles high.
- `frame_drop`, out, 1: one-cycle pulse when an incoming frame is discarded.

## Operation
- Bytes per sample: `B = ceil(DATA_W/8)`. Each sample is sent LSB byte first, with the upper bits of the last byte zero-padded.
- Valid rising edge: `data_valid` high this cycle and `vld_d` low, where `vld_d` is the registered `data_valid` and resets to 0.
- States: `IDLE`, `FILL`, `SEND`.
- `IDLE`:
  - On a valid rising edge, write that sample to address 0 and go to `FILL`.
  - Other valid cycles are ignored, so capture never starts mid-burst.
- `FILL`:
  - Every `data_valid`-high cycle writes `data_re` at the write pointer and increments it. Gaps in valid are allowed.
  - After sample `DEPTH-1` is written, go to `SEND`.
  - The write pointer is `log2(DEPTH)` bits wide and wraps to 0.
- `SEND`:
  - Output is the header (if enabled), then samples 0..`DEPTH-1`, each as `B` bytes.
  - Each byte is framed as start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly `CLK_DIV` cycles.
  - `rx_ready` is sampled only at byte boundaries:
    - High: the next byte starts.
    - Low: the line holds 1 and the state waits.
  - A byte already in progress always completes, even if `rx_ready` drops.
  - When the last stop bit ends, go to `IDLE`.
- `data_valid` is ignored in `SEND`. Every valid rising edge seen in `SEND` pulses `frame_drop` high for one cycle.
- Storage is read one cycle ahead of use, so read latency is hidden.

## Timing
- Reset values: `tx_ready`=0, `data_out`=1, `frame_drop`=0, state `IDLE`, pointers 0, `vld_d`=0. A reset mid-byte forces `data_out`=1 on the next edge and discards the buffer.
- `data_valid` high in the first cycle after reset counts as a rising edge.
- `tx_ready`:
  - Rises one cycle after the edge that writes sample `DEPTH-1`.
  - Falls one cycle after the final stop bit completes, i.e. on the `SEND`→`IDLE` transition.
- Start of transmission: if `rx_ready` is high at the cycle `SEND` is entered, `data_out` goes low on the next edge. Otherwise it goes low on the edge after `rx_ready` is first sampled high.
- Byte spacing: back-to-back bytes occupy exactly `10*CLK_DIV` cycles, with no extra idle cycle when `rx_ready` stays high.
- Minimum frame time: `(H + DEPTH*B)*10*CLK_DIV` cycles, where `H` is the header length in bytes.
- A valid rising edge in the same cycle as the `SEND`→`IDLE` transition is treated as being in `SEND`: it is dropped and pulses `frame_drop`.
- Capture can start the cycle after `IDLE` is entered.

## Configuration
- `FRAME_HEADER_EN`:
  - Defined: each frame is prefixed with the two bytes 0xA5 then 0x5A (`H`=2), sent under the same `rx_ready` pacing.
  - Undefined: no header is sent (`H`=0), and the first byte on the line is sample 0's LSB byte.

## Test plan
Use `DATA_W`=14, `DEPTH`=8, `CLK_DIV`=4 unless stated otherwise.

- **Basic frame:** `rx_ready`=1; feed 8 valid samples 0x1ABC+i. Expect `tx_ready` to rise 1 cycle after the 8th write, then bytes BC 1A BD 1A … C3 1A. Each byte is 40 cycles; the frame is 640 cycles (720 with the header), after which `tx_ready`=0.
- **Flow control:** drop `rx_ready` at cycle 10 of byte 3. Expect byte 3 to complete, the line to stay 1 while `rx_ready`=0, and byte 4's start bit one cycle after `rx_ready` returns high. No data may be lost or duplicated.
- **Gapped valid and burst alignment:** assert valid 1-on/1-off for 8 samples. Expect all 8 captured in order. A burst already high when `IDLE` is re-entered must not be captured until its next rising edge.
- **Drop:** issue a new valid burst during `SEND`. Expect exactly one `frame_drop` pulse, and transmitted content unchanged.
- **Reset mid-byte:** assert `rst` during a data bit. Expect `data_out`=1 and `tx_ready`=0 on the next edge, with no further bytes until a new full frame arrives.
- **Width sweep:** `DATA_W`=8, then 20. Expect `B`=1 and 3 respectively, with the top 4 bits of byte 3 equal to 0 for `DATA_W`=20.
